display_scan_mux: RTL and testbench

Parametrised multiplexed-display scanner for the 7-segment path. It generates its own refresh tick, rotates a one-hot digit select across N_DIGITS positions, and presents the matching nibble of a frame-latched BCD word to the segment decoder. It replaces the external state machine plus combinational digit mux, and sits between the binary-to-BCD converter and the segment decoder / anode drivers.

---
 rtl/display_pkg.sv | 19 +
 rtl/refresh_tick_gen.sv | 42 ++++
 rtl/display_scan_mux.sv | 164 ++++++++++++++++
 tb/tb_display_scan_mux.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
package display_pkg;

  // Default width of one BCD digit.
  localparam int DIGIT_W_DEFAULT = 4;

  // Supported range for the number of scanned positions.
  localparam int N_DIGITS_MIN = 2;
  localparam int N_DIGITS_MAX = 8;

  // Digit value that reads as a blank (leading zero) position.
  localparam logic [3:0] BCD_BLANK = 4'h0;

  // True when exactly one bit of the (zero-extended) select vector is set.
  function automatic logic is_onehot(input logic [N_DIGITS_MAX-1:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 while enabled and raises tick
// on the terminal count, wrapping back to zero. Disabled means frozen.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 27000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_s;

  // Next prescaler count; a tick only exists on an enabled terminal cycle.
  always_comb begin
    tick_s = en && (cnt_q == TERM_CNT);
    if (!en) begin
      cnt_d = cnt_q;
    end else if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed display scanner: rotates a one-hot digit select every refresh
// slot and presents the matching nibble of a frame-latched BCD word.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading-zero slots).
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_W     = DIGIT_W_DEFAULT,
  parameter int REFRESH_DIV = 27000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_DIGITS*DIGIT_W-1:0]  cdu,
  output logic [N_DIGITS-1:0]          sel,
  output logic [DIGIT_W-1:0]           digit,
  output logic [$clog2(N_DIGITS)-1:0]  idx,
  output logic                         frame_start
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FW    = N_DIGITS * DIGIT_W;
  localparam logic [N_DIGITS-1:0] SEL_POS0 = N_DIGITS'(1);

  logic                tick_s;
  logic                wrap_s;
  logic [DIGIT_W-1:0]  digit_sel_s;

  // The ring is the true scan position; sel may differ from it when blanking.
  logic [N_DIGITS-1:0] sel_ring_q, sel_ring_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                frame_start_q, frame_start_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic                blank_s;
  logic [N_DIGITS-1:0] sel_out_q, sel_out_d;
`endif

  refresh_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick_s)
  );

  // Slot advance: rotate select, take a snapshot at frame wrap or on a
  // corrupted select, and pick the digit for the new position.
  always_comb begin
    sel_ring_d    = sel_ring_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    frame_start_d = 1'b0;
    wrap_s        = 1'b0;
    digit_sel_s   = {DIGIT_W{1'b0}};

    if (tick_s) begin
      if (!is_onehot(N_DIGITS_MAX'(sel_ring_q)) || sel_ring_q[N_DIGITS-1]) begin
        wrap_s = 1'b1;
      end else begin
        wrap_s = 1'b0;
      end
      if (wrap_s) begin
        sel_ring_d    = SEL_POS0;
        idx_d         = {IDX_W{1'b0}};
        frame_d       = cdu;
        frame_start_d = 1'b1;
      end else begin
        sel_ring_d    = {sel_ring_q[N_DIGITS-2:0], 1'b0};
        idx_d         = idx_q + IDX_W'(1);
      end
    end else begin
      wrap_s = 1'b0;
    end

    // Position 0 of a new frame reads straight from the incoming snapshot.
    for (int j = 0; j < N_DIGITS; j++) begin
      if (IDX_W'(j) == idx_d) begin
        digit_sel_s = frame_d[j*DIGIT_W +: DIGIT_W];
      end else begin
        digit_sel_s = digit_sel_s;
      end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A slot above position 0 is blank when it and all higher digits are zero.
    blank_s = 1'b0;
    if (idx_d != {IDX_W{1'b0}}) begin
      blank_s = 1'b1;
      for (int j = 0; j < N_DIGITS; j++) begin
        if ((IDX_W'(j) >= idx_d) &&
            (frame_d[j*DIGIT_W +: DIGIT_W] != DIGIT_W'(BCD_BLANK))) begin
          blank_s = 1'b0;
        end else begin
          blank_s = blank_s;
        end
      end
    end else begin
      blank_s = 1'b0;
    end

    sel_out_d = sel_out_q;
    digit_d   = digit_q;
    if (tick_s) begin
      if (blank_s) begin
        sel_out_d = {N_DIGITS{1'b0}};
        digit_d   = {DIGIT_W{1'b0}};
      end else begin
        sel_out_d = sel_ring_d;
        digit_d   = digit_sel_s;
      end
    end else begin
      sel_out_d = sel_out_q;
      digit_d   = digit_q;
    end
`else
    if (tick_s) begin
      digit_d = digit_sel_s;
    end else begin
      digit_d = digit_q;
    end
`endif
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ring_q    <= SEL_POS0;
      idx_q         <= {IDX_W{1'b0}};
      digit_q       <= {DIGIT_W{1'b0}};
      frame_q       <= {FW{1'b0}};
      frame_start_q <= 1'b0;
    end else begin
      sel_ring_q    <= sel_ring_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      frame_q       <= frame_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Visible select, cleared for blanked slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_out_q <= SEL_POS0;
    end else begin
      sel_out_q <= sel_out_d;
    end
  end

  assign sel = sel_out_q;
`else
  assign sel = sel_ring_q;
`endif

  assign idx         = idx_q;
  assign digit       = digit_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with N_DIGITS=4, REFRESH_DIV=4.
module tb_display_scan_mux;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] cdu;
  logic [3:0]  sel;
  logic [3:0]  digit;
  logic [1:0]  idx;
  logic        frame_start;

  int checks;
  int failures;

  display_scan_mux #(
    .N_DIGITS    (4),
    .DIGIT_W     (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cdu         (cdu),
    .sel         (sel),
    .digit       (digit),
    .idx         (idx),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; cdu = 16'h0000;
    step(3);
    rst = 1'b0;
    checks++; if (sel !== 4'b0001) begin failures++; $display("FAIL reset_sel got %b exp 0001", sel); end
    checks++; if (idx !== 2'd0) begin failures++; $display("FAIL reset_idx got %0d exp 0", idx); end
    checks++; if (digit !== 4'h0) begin failures++; $display("FAIL reset_digit got %h exp 0", digit); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got %b exp 0", frame_start); end
  endtask

  task automatic test_scan;
    en = 1'b1; cdu = 16'h1234;
    step(3);
    checks++; if (sel !== 4'b0001) begin failures++; $display("FAIL slot_hold_sel got %b exp 0001", sel); end
    step(1);
    checks++; if (sel !== 4'b0010 || idx !== 2'd1) begin failures++; $display("FAIL first_tick got sel=%b idx=%0d exp 0010/1", sel, idx); end
    step(4);
    checks++; if (sel !== 4'b0100 || idx !== 2'd2) begin failures++; $display("FAIL tick2 got sel=%b idx=%0d exp 0100/2", sel, idx); end
    step(4);
    checks++; if (sel !== 4'b1000 || idx !== 2'd3) begin failures++; $display("FAIL tick3 got sel=%b idx=%0d exp 1000/3", sel, idx); end
    step(4);
    checks++; if (sel !== 4'b0001 || digit !== 4'h4 || idx !== 2'd0 || frame_start !== 1'b1) begin failures++; $display("FAIL wrap1 got sel=%b d=%h idx=%0d fs=%b exp 0001/4/0/1", sel, digit, idx, frame_start); end
    step(1);
    checks++; if (frame_start !== 1'b0 || sel !== 4'b0001) begin failures++; $display("FAIL fs_pulse got fs=%b sel=%b exp 0/0001", frame_start, sel); end
    step(3);
    checks++; if (sel !== 4'b0010 || digit !== 4'h3) begin failures++; $display("FAIL slot1 got sel=%b d=%h exp 0010/3", sel, digit); end
  endtask

  task automatic test_no_tearing;
    cdu = 16'h5678;
    step(4);
    checks++; if (sel !== 4'b0100 || digit !== 4'h2) begin failures++; $display("FAIL tear_slot2 got sel=%b d=%h exp 0100/2", sel, digit); end
    step(4);
    checks++; if (sel !== 4'b1000 || digit !== 4'h1) begin failures++; $display("FAIL tear_slot3 got sel=%b d=%h exp 1000/1", sel, digit); end
    step(4);
    checks++; if (sel !== 4'b0001 || digit !== 4'h8 || frame_start !== 1'b1) begin failures++; $display("FAIL new_frame got sel=%b d=%h fs=%b exp 0001/8/1", sel, digit, frame_start); end
  endtask

  task automatic test_enable_freeze;
    step(1);
    en = 1'b0;
    step(10);
    checks++; if (sel !== 4'b0001 || digit !== 4'h8 || idx !== 2'd0 || frame_start !== 1'b0) begin failures++; $display("FAIL freeze got sel=%b d=%h idx=%0d fs=%b exp 0001/8/0/0", sel, digit, idx, frame_start); end
    en = 1'b1;
    step(2);
    checks++; if (sel !== 4'b0001) begin failures++; $display("FAIL resume_hold got sel=%b exp 0001", sel); end
    step(1);
    checks++; if (sel !== 4'b0010 || digit !== 4'h7) begin failures++; $display("FAIL resume_tick got sel=%b d=%h exp 0010/7", sel, digit); end
    step(3);
    en = 1'b0;
    step(3);
    checks++; if (sel !== 4'b0010) begin failures++; $display("FAIL tc_suppress got sel=%b exp 0010", sel); end
    en = 1'b1;
    step(1);
    checks++; if (sel !== 4'b0100 || digit !== 4'h6 || idx !== 2'd2) begin failures++; $display("FAIL tc_resume got sel=%b d=%h idx=%0d exp 0100/6/2", sel, digit, idx); end
  endtask

  task automatic test_async_reset;
    step(2);
    #2 rst = 1'b1;
    #1;
    checks++; if (sel !== 4'b0001 || digit !== 4'h0 || idx !== 2'd0 || frame_start !== 1'b0) begin failures++; $display("FAIL async_rst got sel=%b d=%h idx=%0d fs=%b exp 0001/0/0/0", sel, digit, idx, frame_start); end
    rst = 1'b0;
  endtask

  task automatic test_recovery;
    step(1);
    step(1);
    cdu = 16'h9876;
    force dut.sel_ring_q = 4'b0110;
    #1;
    release dut.sel_ring_q;
`ifndef LEADING_ZERO_BLANK_EN
    checks++; if (sel !== 4'b0110) begin failures++; $display("FAIL force_sel got %b exp 0110", sel); end
`endif
    step(1);
`ifndef LEADING_ZERO_BLANK_EN
    checks++; if (sel !== 4'b0110) begin failures++; $display("FAIL force_hold got %b exp 0110", sel); end
`endif
    step(1);
    checks++; if (sel !== 4'b0001 || digit !== 4'h6 || idx !== 2'd0 || frame_start !== 1'b1) begin failures++; $display("FAIL recover got sel=%b d=%h idx=%0d fs=%b exp 0001/6/0/1", sel, digit, idx, frame_start); end
    step(4);
    checks++; if (sel !== 4'b0010 || digit !== 4'h7) begin failures++; $display("FAIL recover_slot1 got sel=%b d=%h exp 0010/7", sel, digit); end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank;
    int budget;
    cdu = 16'h0042;
    budget = 0;
    step(1);
    while (frame_start !== 1'b1 && budget < 40) begin
      step(1);
      budget++;
    end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL blank_wait got fs=%b exp 1", frame_start); end
    checks++; if (sel !== 4'b0001 || digit !== 4'h2) begin failures++; $display("FAIL blank_pos0 got sel=%b d=%h exp 0001/2", sel, digit); end
    step(4);
    checks++; if (sel !== 4'b0010 || digit !== 4'h4) begin failures++; $display("FAIL blank_pos1 got sel=%b d=%h exp 0010/4", sel, digit); end
    step(4);
    checks++; if (sel !== 4'b0000 || digit !== 4'h0 || idx !== 2'd2) begin failures++; $display("FAIL blank_pos2 got sel=%b d=%h idx=%0d exp 0000/0/2", sel, digit, idx); end
    cdu = 16'h0000;
    step(4);
    checks++; if (sel !== 4'b0000 || idx !== 2'd3) begin failures++; $display("FAIL blank_pos3 got sel=%b idx=%0d exp 0000/3", sel, idx); end
    step(4);
    checks++; if (sel !== 4'b0001 || digit !== 4'h0 || frame_start !== 1'b1) begin failures++; $display("FAIL zero_pos0 got sel=%b d=%h fs=%b exp 0001/0/1", sel, digit, frame_start); end
    step(4);
    checks++; if (sel !== 4'b0000 || idx !== 2'd1) begin failures++; $display("FAIL zero_pos1 got sel=%b idx=%0d exp 0000/1", sel, idx); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    cdu      = 16'h0000;
    test_reset;
    test_scan;
    test_no_tearing;
    test_enable_freeze;
    test_async_reset;
    test_recovery;
`ifdef LEADING_ZERO_BLANK_EN
    test_blank;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
